uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the data-memory port of the openmips core, inside openmips_min_sopc, beside data_ram.
- The CPU writes bytes into an internal FIFO. An 8N1 serializer drains the FIFO onto txd_o.
- Gives the SOPC bench and board observable output.
- Read data is combinational, matching the data_ram timing the core expects. Writes and all state are sequential.

Parameters:
- FIFO_DEPTH, 8, number of byte entries in the transmit FIFO; power of 2, minimum 2.
- DEFAULT_DIV, 434, reset value of the divisor (50 MHz / 115200 baud).

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- rst  in  1  reset, asynchronous, active-low.
- ce_i  in  1  peripheral selected by top-level address decode.
- we_i  in  1  write strobe; valid only with ce_i.
- addr_i  in  4  byte offset; only [3:2] decoded.
- sel_i  in  4  byte enables; the write takes effect only if sel_i[0]=1.
- data_i  in  32  write data.
- data_o  out  32  read data, combinational.
- txd_o  out  1  serial output, idles high.
- irq_o  out  1  high while the FIFO is empty and the shifter is idle (tx done).

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-low.
  - While rst=0, all state clears immediately, independent of clk: FIFO empty, overflow=0, divisor=DEFAULT_DIV, FSM=IDLE, txd_o=1, irq_o=1.
  - A reset asserted mid-frame truncates the frame; txd_o returns high with no clock.
- Register map, selected by addr_i[3:2]:
  - 0 TXDATA: a write pushes data_i[7:0]; reads return 0.
  - 1 STATUS (read): [0] busy (FSM != IDLE), [1] full, [2] empty, [3] overflow, [11:8] fifo count, other bits 0. Writing 1 to data_i[3] clears overflow.
  - 2 DIVISOR: [15:0] R/W; reads return zero-extended. Value 0 is treated as 1.
  - 3: reserved; reads return 0, writes are ignored.
- Accesses with ce_i=0 or sel_i[0]=0 have no effect; data_o=0 when ce_i=0.
- Register writes occur on the rising edge of clk when ce_i & we_i & sel_i[0].
- FIFO:
  - A push while full drops the byte and sets overflow (sticky).
  - Push and pop in the same cycle leave the count unchanged. A push to an empty FIFO while the FSM pops is impossible, because a pop requires non-empty.
  - Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- Serializer FSM, IDLE -> START -> DATA -> STOP -> (START | IDLE):
  - IDLE: txd_o=1. If the FIFO is non-empty, pop the head into the shift register, latch the divisor into div_q, and go to START on the next edge.
  - START: txd_o=0 for div_q cycles.
  - DATA: 8 bits, LSB first, div_q cycles each; a 3-bit index counts 0..7.
  - STOP: txd_o=1 for div_q cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
  - Bit timer: counts down from div_q-1; the bit boundary is the cycle with timer=0.
  - Latency: a write accepted at edge N with an idle, empty block puts the start bit on txd_o from edge N+2 (pop at N+1, START at N+2).
- Divisor writes mid-frame do not affect the current frame; div_q is relatched at each frame start.
- txd_o is driven from a register; it is glitch-free.

Decomposition:
- Add to defines.h:
  - UART register offset constants.
  - STATUS bit positions.
  - the FSM state encoding (`UartIdle/`UartStart/`UartData/`UartStop, 2 bits).
  - `UartDivWidth 16.
- One sub-module, uart_fifo: synchronous FIFO, parameterised on width and depth, with push/pop/full/empty/count.
- uart_tx_mmio holds the register decode, overflow flag, divisor, and serializer FSM.
- openmips_min_sopc instantiates it on the data bus and routes txd_o to a top-level pin.

Test Plan:
- Reset: hold rst=0 for 19 ns. Required: txd_o=1, STATUS=0x00000004, DIVISOR reads 434. Assert rst=0 mid-frame: txd_o=1 within the same timestep.
- Single byte: DIVISOR=4, write TXDATA=0x55. Required: from edge N+2, txd_o = 0, 1,0,1,0,1,0,1,0, 1, each level held 4 cycles (40 cycles total); busy=1 throughout; then IDLE and irq_o=1.
- Back-to-back: DIVISOR=2, write 0x01 then 0x80. Required: the stop bit of frame 1 is followed immediately by the start bit of frame 2; total 40 cycles with no gap.
- Full/overflow: DIVISOR=1000, write 9 bytes 0x00..0x08 quickly.
  - Byte 0 is popped, so the 8 writes that follow fill the FIFO: full=1, count=8, and no byte is lost.
  - A 10th write sets overflow=1, and that byte never appears on txd_o.
  - Writing STATUS with bit3=1 clears overflow.
- Divisor edges: DIVISOR=0 gives 1-cycle bits (10 cycles per frame). Changing DIVISOR from 4 to 8 mid-frame keeps 4-cycle bits until the next frame.
- Decode: writes with sel_i=4'b0010, with ce_i=0, or to offset 0xC leave the FIFO count at 0; a read with ce_i=0 returns 0.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// STATUS bit positions, serializer state encoding and divisor width.
package uart_tx_mmio_pkg;

    localparam int UART_DIV_W = 16;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // A programmed divisor of zero behaves as one cycle per bit.
    function automatic logic [UART_DIV_W-1:0] eff_div(input logic [UART_DIV_W-1:0] d);
        return (d == '0) ? UART_DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Pushes while full and pops while empty are ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, sticky overflow,
// programmable divisor and the serializer that drains the byte FIFO onto txd_o.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd_o,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]            reg_sel;
    logic                  wr_en, push, pop, load;
    logic [7:0]            fifo_dout;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;

    logic                  ovf_q, ovf_d;
    logic [UART_DIV_W-1:0] div_reg_q, div_reg_d;
    uart_state_e           state_q, state_d;
    logic [UART_DIV_W-1:0] timer_q, timer_d;
    logic [UART_DIV_W-1:0] div_q, div_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  irq_q, irq_d;
    logic                  bit_end;
    logic                  unused_ok;

    assign reg_sel   = addr_i[3:2];
    assign wr_en     = ce_i && we_i && sel_i[0];
    assign push      = wr_en && (reg_sel == REG_TXDATA);
    assign bit_end   = (timer_q == '0);
    assign unused_ok = ^{addr_i[1:0], sel_i[3:1], data_i[31:16]};

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_i[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        ovf_d     = ovf_q;
        div_reg_d = div_reg_q;
        if (push && fifo_full) ovf_d = 1'b1;
        if (wr_en && (reg_sel == REG_STATUS) && data_i[ST_OVF]) ovf_d = 1'b0;
        if (wr_en && (reg_sel == REG_DIVISOR)) div_reg_d = data_i[UART_DIV_W-1:0];
    end

    // A frame loads from idle, or straight out of the stop bit when more data waits.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        load      = !fifo_empty &&
                    ((state_q == UART_IDLE) || ((state_q == UART_STOP) && bit_end));
        pop       = load;
        case (state_q)
            UART_IDLE: ;
            UART_START: begin
                if (bit_end) begin
                    state_d   = UART_DATA;
                    timer_d   = div_q - UART_DIV_W'(1);
                    bit_idx_d = 3'd0;
                end else begin
                    timer_d = timer_q - UART_DIV_W'(1);
                end
            end
            UART_DATA: begin
                if (bit_end) begin
                    timer_d = div_q - UART_DIV_W'(1);
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) state_d = UART_STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    timer_d = timer_q - UART_DIV_W'(1);
                end
            end
            UART_STOP: begin
                if (bit_end) state_d = UART_IDLE;
                else timer_d = timer_q - UART_DIV_W'(1);
            end
            default: state_d = UART_IDLE;
        endcase
        if (load) begin
            state_d = UART_START;
            shift_d = fifo_dout;
            div_d   = eff_div(div_reg_q);
            timer_d = eff_div(div_reg_q) - UART_DIV_W'(1);
        end
    end

    // Line level, busy and irq follow the state one cycle later so all three stay aligned.
    always_comb begin
        case (state_q)
            UART_START: txd_d = 1'b0;
            UART_DATA:  txd_d = shift_q[0];
            default:    txd_d = 1'b1;
        endcase
        busy_d = (state_q != UART_IDLE);
        irq_d  = fifo_empty && (state_q == UART_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q     <= 1'b0;
            div_reg_q <= UART_DIV_W'(DEFAULT_DIV);
            state_q   <= UART_IDLE;
            timer_q   <= '0;
            div_q     <= UART_DIV_W'(1);
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            irq_q     <= 1'b1;
        end else begin
            ovf_q     <= ovf_d;
            div_reg_q <= div_reg_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
        end
    end

    assign txd_o = txd_q;
    assign irq_o = irq_q;

    always_comb begin
        data_o = 32'h0;
        if (ce_i) begin
            case (reg_sel)
                REG_STATUS: begin
                    data_o[ST_BUSY]           = busy_q;
                    data_o[ST_FULL]           = fifo_full;
                    data_o[ST_EMPTY]          = fifo_empty;
                    data_o[ST_OVF]            = ovf_q;
                    data_o[ST_CNT_LSB +: 4]   = 4'(fifo_count);
                end
                REG_DIVISOR: data_o[UART_DIV_W-1:0] = div_reg_q;
                default:     data_o = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: reset, decode, single/back-to-back frames,
// divisor corner cases, FIFO full/overflow and mid-frame reset.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0, we_i = 1'b0;
    logic [3:0]  addr_i = 4'h0, sel_i = 4'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic        txd_o, irq_o;

    int checks = 0;
    int fails  = 0;

    uart_tx_mmio dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .txd_o  (txd_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s = 4'b0001, input logic ce = 1'b1);
        ce_i = ce; we_i = 1'b1; addr_i = a; sel_i = s; data_i = d;
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0; sel_i = 4'h0; data_i = 32'h0;
    endtask

    task automatic set_rd(input logic [3:0] a);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a; sel_i = 4'b0001; data_i = 32'h0;
    endtask

    // Samples one frame starting at the next falling edge; expects start, LSB-first data, stop.
    task automatic check_frame(input logic [7:0] b, input int div, input string tag);
        int bi;
        logic exp;
        set_rd(4'h4);
        for (int i = 0; i < 10 * div; i++) begin
            @(negedge clk);
            bi = i / div;
            if (bi == 0)      exp = 1'b0;
            else if (bi == 9) exp = 1'b1;
            else              exp = b[bi-1];
            chk($sformatf("%s_bit%0d", tag, i), {31'h0, txd_o}, {31'h0, exp});
            chk($sformatf("%s_busy%0d", tag, i), {31'h0, data_o[0]}, 32'h1);
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        set_rd(4'h4);
        #1;
        chk({tag, "_status"}, data_o, 32'h0000_0004);
        chk({tag, "_irq"}, {31'h0, irq_o}, 32'h1);
        chk({tag, "_txd"}, {31'h0, txd_o}, 32'h1);
    endtask

    initial begin
        bit seen;

        // Reset state
        #10;
        chk("rst_txd", {31'h0, txd_o}, 32'h1);
        chk("rst_irq", {31'h0, irq_o}, 32'h1);
        set_rd(4'h4); #1;
        chk("rst_status", data_o, 32'h0000_0004);
        set_rd(4'h8); #1;
        chk("rst_div", data_o, 32'd434);
        #7 rst = 1'b1;
        @(negedge clk);

        // Decode: none of these reach the FIFO
        wr(4'h0, 32'hAA, 4'b0010);
        wr(4'h0, 32'hAB, 4'b0001, 1'b0);
        wr(4'hC, 32'hAC);
        @(negedge clk);
        set_rd(4'h4); #1;
        chk("dec_status", data_o, 32'h0000_0004);
        chk("dec_txd", {31'h0, txd_o}, 32'h1);
        ce_i = 1'b0; #1;
        chk("dec_ce0_read", data_o, 32'h0);
        set_rd(4'hC); #1;
        chk("dec_rsvd_read", data_o, 32'h0);
        set_rd(4'h0); #1;
        chk("dec_txdata_read", data_o, 32'h0);
        @(negedge clk);

        // Single byte, 4 cycles per bit
        wr(4'h8, 32'd4);
        set_rd(4'h8); #1;
        chk("div4_read", data_o, 32'd4);
        @(negedge clk);
        wr(4'h0, 32'h55);
        @(negedge clk);
        check_frame(8'h55, 4, "single");
        expect_idle("single_end");

        // Back-to-back frames with no idle gap
        @(negedge clk);
        wr(4'h8, 32'd2);
        wr(4'h0, 32'h01);
        wr(4'h0, 32'h80);
        check_frame(8'h01, 2, "b2b_f1");
        check_frame(8'h80, 2, "b2b_f2");
        expect_idle("b2b_end");

        // Divisor 0 acts as 1
        @(negedge clk);
        wr(4'h8, 32'd0);
        set_rd(4'h8); #1;
        chk("div0_read", data_o, 32'd0);
        @(negedge clk);
        wr(4'h0, 32'hA5);
        @(negedge clk);
        check_frame(8'hA5, 1, "div0");
        expect_idle("div0_end");

        // Divisor change mid-frame only applies to the next frame
        @(negedge clk);
        wr(4'h8, 32'd4);
        wr(4'h0, 32'h3C);
        wr(4'h8, 32'd8);
        check_frame(8'h3C, 4, "chg_old");
        @(negedge clk);
        wr(4'h0, 32'hC3);
        @(negedge clk);
        check_frame(8'hC3, 8, "chg_new");
        expect_idle("chg_end");

        // Fill, overflow and clear
        @(negedge clk);
        wr(4'h8, 32'd1000);
        for (int k = 0; k < 9; k++) wr(4'h0, k);
        set_rd(4'h4); #1;
        chk("full_status", data_o, 32'h0000_0803);
        @(negedge clk);
        wr(4'h0, 32'h09);
        set_rd(4'h4); #1;
        chk("ovf_status", data_o, 32'h0000_080B);
        @(negedge clk);
        wr(4'h4, 32'h8);
        set_rd(4'h4); #1;
        chk("ovf_clear", data_o, 32'h0000_0803);
        @(negedge clk);
        wr(4'h8, 32'd1);
        set_rd(4'h4);
        seen = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (data_o[11:8] == 4'd7) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ovf_wait_frame0", {31'h0, seen}, 32'h1);
        for (int k = 1; k <= 8; k++) check_frame(8'(k), 1, $sformatf("fill_b%0d", k));
        @(negedge clk);
        expect_idle("fill_end");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("no_byte9_%0d", i), {31'h0, txd_o}, 32'h1);
        end

        // Mid-frame reset
        wr(4'h8, 32'd4);
        wr(4'h0, 32'h00);
        repeat (6) @(negedge clk);
        chk("midrst_pre_txd", {31'h0, txd_o}, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_txd", {31'h0, txd_o}, 32'h1);
        chk("midrst_irq", {31'h0, irq_o}, 32'h1);
        set_rd(4'h4); #1;
        chk("midrst_status", data_o, 32'h0000_0004);
        set_rd(4'h8); #1;
        chk("midrst_div", data_o, 32'd434);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        expect_idle("post_rst");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
